// File: rtl/wb_write_port_if.sv
// wb_write_port_if: MEM-stage inputs, MDU result handshake and register-file write port of the write-back stage.
interface wb_write_port_if #(
   parameter int AW = 5,
   parameter int DW = 32
);
   logic          mem_valid;
   logic          mem_regwrite;
   logic          mem_memtoreg;
   logic [AW-1:0] mem_rd;
   logic [DW-1:0] mem_alu_result;
   logic [DW-1:0] mem_read_data;
   logic          mdu_valid;
   logic [AW-1:0] mdu_rd;
   logic [DW-1:0] mdu_data;
   logic          mdu_ready;
   logic          regwrite;
   logic [AW-1:0] rd;
   logic [DW-1:0] writedata;
   logic          stall_req;
   logic [31:0]   pending_mask;
   modport master (
      output mem_valid, mem_regwrite, mem_memtoreg, mem_rd, mem_alu_result, mem_read_data,
      output mdu_valid, mdu_rd, mdu_data,
      input  mdu_ready, regwrite, rd, writedata, stall_req, pending_mask
   );
   modport slave (
      input  mem_valid, mem_regwrite, mem_memtoreg, mem_rd, mem_alu_result, mem_read_data,
      input  mdu_valid, mdu_rd, mdu_data,
      output mdu_ready, regwrite, rd, writedata, stall_req, pending_mask
   );
endinterface

// File: rtl/wb_write_port.sv
// wb_write_port: MEM/WB latch plus MDU result FIFO merged onto the single register-file write port.
module wb_write_port #(
   parameter int FIFO_DEPTH = 2,
   parameter int AW = 5,
   parameter int DW = 32
) (
   input logic          clk,
   input logic          rst,
   wb_write_port_if.slave bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   logic          wb_valid;
   logic          wb_regwrite;
   logic [AW-1:0] wb_rd;
   logic [DW-1:0] wb_data;
   logic [AW-1:0] fifo_rd [FIFO_DEPTH];
   logic [DW-1:0] fifo_data [FIFO_DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic [CW-1:0] reg_cnt [1:31];
   logic          pipe_wr;
   logic          full;
   logic          pop;
   logic          push;
   logic [AW-1:0] head_rd;
   always_comb begin
      head_rd = fifo_rd[head];
      full = count == CW'(FIFO_DEPTH);
      pipe_wr = wb_valid & wb_regwrite & (wb_rd != '0);
      pop = !pipe_wr & (count != '0);
      bus.mdu_ready = !full | pop;
      push = bus.mdu_valid & bus.mdu_ready;
      bus.stall_req = full & pipe_wr & bus.mdu_valid;
      bus.regwrite = pipe_wr | (pop & (head_rd != '0));
      bus.rd = pipe_wr ? wb_rd : head_rd;
      bus.writedata = pipe_wr ? wb_data : fifo_data[head];
      bus.pending_mask = '0;
      for (int i = 1; i < 32; i++) bus.pending_mask[i] = reg_cnt[i] != '0;
   end
   // A stall retires the current pipeline write and leaves a bubble so the FIFO can drain next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid <= 1'b0;
         head <= '0;
         tail <= '0;
         count <= '0;
         for (int i = 1; i < 32; i++) reg_cnt[i] <= '0;
      end else begin
         if (bus.stall_req) wb_valid <= 1'b0;
         else begin
            wb_valid <= bus.mem_valid;
            wb_regwrite <= bus.mem_regwrite;
            wb_rd <= bus.mem_rd;
            wb_data <= bus.mem_memtoreg ? bus.mem_read_data : bus.mem_alu_result;
         end
         if (push) begin
            fifo_rd[tail] <= bus.mdu_rd;
            fifo_data[tail] <= bus.mdu_data;
            tail <= tail + 1'b1;
         end
         if (pop) head <= head + 1'b1;
         count <= count + CW'(push) - CW'(pop);
         for (int i = 1; i < 32; i++)
            reg_cnt[i] <= reg_cnt[i] + CW'(push && bus.mdu_rd == AW'(i)) - CW'(pop && head_rd == AW'(i));
      end
   end
endmodule

// File: tb/tb_wb_write_port.sv
// tb_wb_write_port: scenario tasks with an expected-write scoreboard for wb_write_port.
module tb_wb_write_port;
   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wr_t;
   logic clk = 1'b0;
   logic rst;
   int   checks;
   int   errors;
   wr_t  exp_q[$];
   wb_write_port_if #(.AW(5), .DW(32)) bus ();
   wb_write_port #(.FIFO_DEPTH(2), .AW(5), .DW(32)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic adv();
      @(posedge clk);
      #1;
   endtask
   // Waits for the mid-cycle sample point and retires any observed write against the scoreboard.
   task automatic mon();
      wr_t e;
      @(negedge clk);
      if (bus.regwrite === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL write: unexpected rd=%0d data=%h, required no write", bus.rd, bus.writedata);
         end else begin
            e = exp_q.pop_front();
            if (bus.rd !== e.rd || bus.writedata !== e.data) begin
               errors++;
               $display("FAIL write: got rd=%0d data=%h, required rd=%0d data=%h", bus.rd, bus.writedata, e.rd, e.data);
            end
         end
      end
   endtask
   task automatic cyc();
      mon();
      adv();
   endtask
   task automatic pipe(input logic v, input logic [4:0] r, input logic [31:0] alu, input logic [31:0] ld, input logic m2r);
      bus.mem_valid = v;
      bus.mem_regwrite = v;
      bus.mem_rd = r;
      bus.mem_alu_result = alu;
      bus.mem_read_data = ld;
      bus.mem_memtoreg = m2r;
   endtask
   task automatic mdu(input logic v, input logic [4:0] r, input logic [31:0] d);
      bus.mdu_valid = v;
      bus.mdu_rd = r;
      bus.mdu_data = d;
   endtask
   task automatic idle();
      pipe(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
      mdu(1'b0, 5'd0, 32'd0);
   endtask
   task automatic test_reset();
      @(negedge clk);
      checks += 4;
      if (bus.regwrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b, required 0", bus.regwrite); end
      if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b, required 0", bus.stall_req); end
      if (bus.mdu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", bus.mdu_ready); end
      if (bus.pending_mask !== 32'h0) begin errors++; $display("FAIL reset_pending: got %h, required 0", bus.pending_mask); end
      adv();
   endtask
   task automatic test_pipeline();
      pipe(1'b1, 5'd5, 32'h0000_1234, 32'hFFFF_0000, 1'b0);
      exp_q.push_back('{5'd5, 32'h0000_1234});
      cyc();
      pipe(1'b1, 5'd7, 32'h0000_5555, 32'hDEAD_BEEF, 1'b1);
      exp_q.push_back('{5'd7, 32'hDEAD_BEEF});
      cyc();
      idle();
      cyc();
      mon();
      checks += 2;
      if (bus.regwrite !== 1'b0) begin errors++; $display("FAIL pipe_idle: regwrite got %b, required 0", bus.regwrite); end
      if (exp_q.size() != 0) begin errors++; $display("FAIL pipe_drain: %0d writes missing, required 0", exp_q.size()); end
      exp_q.delete();
      adv();
   endtask
   task automatic test_rd0_filter();
      pipe(1'b1, 5'd0, 32'h0000_AAAA, 32'h0, 1'b0);
      cyc();
      idle();
      mdu(1'b1, 5'd0, 32'h0000_0077);
      mon();
      checks += 2;
      if (bus.regwrite !== 1'b0) begin errors++; $display("FAIL rd0_pipe: regwrite got %b, required 0", bus.regwrite); end
      if (bus.mdu_ready !== 1'b1) begin errors++; $display("FAIL rd0_ready: got %b, required 1", bus.mdu_ready); end
      adv();
      mdu(1'b0, 5'd0, 32'h0);
      mon();
      checks += 2;
      if (bus.regwrite !== 1'b0) begin errors++; $display("FAIL rd0_mdu: regwrite got %b, required 0", bus.regwrite); end
      if (bus.pending_mask !== 32'h0) begin errors++; $display("FAIL rd0_pending: got %h, required 0", bus.pending_mask); end
      adv();
      cyc();
   endtask
   task automatic test_mdu_idle();
      mdu(1'b1, 5'd9, 32'h0000_0042);
      mon();
      checks++;
      if (bus.mdu_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b, required 1", bus.mdu_ready); end
      exp_q.push_back('{5'd9, 32'h0000_0042});
      adv();
      mdu(1'b0, 5'd0, 32'h0);
      mon();
      checks++;
      if (bus.pending_mask !== 32'h0000_0200) begin errors++; $display("FAIL idle_pending_set: got %h, required 00000200", bus.pending_mask); end
      adv();
      mon();
      checks += 2;
      if (bus.pending_mask !== 32'h0) begin errors++; $display("FAIL idle_pending_clr: got %h, required 0", bus.pending_mask); end
      if (exp_q.size() != 0) begin errors++; $display("FAIL idle_drain: %0d writes missing, required 0", exp_q.size()); end
      exp_q.delete();
      adv();
   endtask
   task automatic test_back_to_back();
      logic       pv [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
      logic [4:0] prd [8] = '{10, 12, 14, 14, 0, 0, 0, 0};
      logic [4:0] mrd [8] = '{11, 13, 15, 15, 0, 0, 0, 0};
      logic       st [8] = '{0, 0, 1, 0, 0, 0, 0, 0};
      logic       rdy [8] = '{1, 1, 0, 1, 0, 1, 1, 1};
      for (int i = 0; i < 8; i++) begin
         pipe(pv[i], prd[i], 32'hA000_0000 + 32'(prd[i]), 32'h0, 1'b0);
         mdu(pv[i], mrd[i], 32'h0000_0100 + 32'(mrd[i]));
         if (i == 0) exp_q.push_back('{5'd10, 32'hA000_000A});
         if (i == 1) begin
            exp_q.push_back('{5'd12, 32'hA000_000C});
            exp_q.push_back('{5'd11, 32'h0000_010B});
         end
         if (i == 2) begin
            exp_q.push_back('{5'd14, 32'hA000_000E});
            exp_q.push_back('{5'd13, 32'h0000_010D});
            exp_q.push_back('{5'd15, 32'h0000_010F});
         end
         mon();
         checks += 2;
         if (bus.stall_req !== st[i]) begin errors++; $display("FAIL b2b_stall[%0d]: got %b, required %b", i, bus.stall_req, st[i]); end
         if (bus.mdu_ready !== rdy[i]) begin errors++; $display("FAIL b2b_ready[%0d]: got %b, required %b", i, bus.mdu_ready, rdy[i]); end
         if (i == 2) begin
            checks++;
            if (bus.pending_mask !== 32'h0000_2800) begin errors++; $display("FAIL b2b_pending: got %h, required 00002800", bus.pending_mask); end
         end
         if (i == 7) begin
            checks += 2;
            if (bus.pending_mask !== 32'h0) begin errors++; $display("FAIL b2b_pending_end: got %h, required 0", bus.pending_mask); end
            if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: %0d writes missing, required 0", exp_q.size()); end
            exp_q.delete();
         end
         adv();
      end
   endtask
   task automatic test_duplicate();
      logic p3 [6] = '{0, 1, 1, 1, 1, 0};
      for (int i = 0; i < 6; i++) begin
         pipe(i < 2, 5'(20 + i), 32'hB000_0000 + 32'(i), 32'h0, 1'b0);
         mdu(i < 2, 5'd3, 32'(i + 1));
         if (i == 0) exp_q.push_back('{5'd20, 32'hB000_0000});
         if (i == 1) begin
            exp_q.push_back('{5'd21, 32'hB000_0001});
            exp_q.push_back('{5'd3, 32'h0000_0001});
            exp_q.push_back('{5'd3, 32'h0000_0002});
         end
         mon();
         checks++;
         if (bus.pending_mask[3] !== p3[i]) begin errors++; $display("FAIL dup_pending[%0d]: got %b, required %b", i, bus.pending_mask[3], p3[i]); end
         adv();
      end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL dup_drain: %0d writes missing, required 0", exp_q.size()); end
      exp_q.delete();
   endtask
   task automatic test_reset_mid();
      pipe(1'b1, 5'd22, 32'hC000_0016, 32'h0, 1'b0);
      mdu(1'b1, 5'd4, 32'h0000_000A);
      exp_q.push_back('{5'd22, 32'hC000_0016});
      cyc();
      pipe(1'b1, 5'd23, 32'hC000_0017, 32'h0, 1'b0);
      mdu(1'b1, 5'd6, 32'h0000_000B);
      exp_q.push_back('{5'd23, 32'hC000_0017});
      cyc();
      idle();
      rst = 1'b1;
      mon();
      checks += 2;
      if (bus.pending_mask !== 32'h0000_0050) begin errors++; $display("FAIL mid_pending_full: got %h, required 00000050", bus.pending_mask); end
      if (bus.mdu_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_full: got %b, required 0", bus.mdu_ready); end
      adv();
      rst = 1'b0;
      mon();
      checks += 3;
      if (bus.regwrite !== 1'b0) begin errors++; $display("FAIL mid_regwrite: got %b, required 0", bus.regwrite); end
      if (bus.pending_mask !== 32'h0) begin errors++; $display("FAIL mid_pending: got %h, required 0", bus.pending_mask); end
      if (bus.mdu_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b, required 1", bus.mdu_ready); end
      adv();
      cyc();
      cyc();
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL mid_drain: %0d writes missing, required 0", exp_q.size()); end
      exp_q.delete();
   endtask
   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      test_reset();
      test_pipeline();
      test_rd0_filter();
      test_mdu_idle();
      test_back_to_back();
      test_duplicate();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
